board_renderer: RTL and testbench
=================================

# board_renderer

Sequential renderer that paints the nine tic-tac-toe cells onto the VGA frame buffer. The block sits between the game-state register (the 18-bit `grid`) and the VGA adapter's pixel-write port. On a `start` pulse it snapshots the board, walks cells 0–8 in row-major order, and fills a CELL_SIZE×CELL_SIZE square per cell, emitting one plotted pixel per clock.

## Interface
- `CELL_SIZE`, default 20: square edge in pixels; legal range 1–30. The cell pitch is 30, so the upper bound prevents squares from overlapping.
- `clk` input 1: system clock. The block uses one clock domain.
- `reset` input 1: asynchronous, active-high reset. It returns all state and outputs to their reset values immediately.
- `start` input 1: single-cycle request to redraw the board. It is sampled only in IDLE.
- `grid` input 18: board state, 2 bits per cell.
  - Cell k occupies `grid[17-2k:16-2k]`; cell 0 is top-left.
  - Encoding: 0 empty, 1 O, 2 X, 3 reserved.
- `x` output 8: pixel column for the VGA adapter.
- `y` output 7: pixel row for the VGA adapter.
- `colour` output 3: pixel colour, RGB with 1 bit each.
- `plot` output 1: pixel write enable; one pixel is written per cycle while high.
- `busy` output 1: high from the first cycle after an accepted `start` through the DONE cycle.
- `done` output 1: one-cycle pulse after the last pixel is written.

## Operation
- **States**: IDLE, LOAD, DRAW, DONE.
- **IDLE**
  - With `start`=1: latch `grid` into `grid_q`, set cell index k=0, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**: register per-cell values from `grid_q`, then clear px and py and go to DRAW.
  - Position, with row r=k/3 and column c=k%3: `base_x = 37 + 30c`, `base_y = 7 + 30r`.
  - Colour from the cell code: 0→3'b111 (white), 1→3'b011 (light blue), 2→3'b101 (purple), 3→3'b000 (black).
- **DRAW**: each cycle drive `x = base_x+px`, `y = base_y+py`, `colour = cell colour`, `plot = 1`.
  - px increments every cycle. When px reaches CELL_SIZE-1 it wraps to 0 and py increments.
  - On the pixel with px = py = CELL_SIZE-1:
    - if k<8, increment k and go to LOAD;
    - if k=8, go to DONE.
- **DONE**: drive `done` = 1 and `plot` = 0, then go to IDLE.
- **Snapshot rule**: `grid` changes after the snapshot do not affect the frame in progress.
- **Ignored start**: `start` in LOAD, DRAW or DONE is ignored; it is neither queued nor allowed to restart the frame.
- **Width rules**:
  - The largest x is 97+29 = 126 and the largest y is 67+29 = 96, so both fit their widths.
  - Additions are unsigned with no truncation.
  - Counters px, py are 5 bits; k is 4 bits.
- **Reserved code**: cell code 3 draws black and is never an error.

## Timing
- **Reset values**: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0. State is IDLE and k, px, py, `grid_q` are all 0.
- **Registered outputs**: all outputs are registered, so no combinational path runs from inputs to outputs.
- **Start latency**: `start` is sampled at edge t0. LOAD for cell 0 occupies cycle t0+1, and the first `plot`=1 appears in cycle t0+2.
- **Per-cell cost**: 1 LOAD cycle + CELL_SIZE² DRAW cycles.
- **Frame length**: `done` is high in cycle t0 + 9·(1+CELL_SIZE²) + 1. With the default of 20 that is t0+3610.
- **Plot gaps**: `plot` is low during each LOAD cycle, one gap between consecutive cells. The VGA adapter tolerates these gaps.
- **Back-to-back frames**: `start` asserted in the same cycle as `done` is ignored. `start` in the following cycle (IDLE) is accepted.
- **Reset mid-frame**: output returns to reset values asynchronously. No `done` is produced. The next `start` begins from cell 0.

## Structure
- **Shared package `ttt_pkg`** holds:
  - cell codes: EMPTY=0, O=1, X=2;
  - colour constants: WHITE, LBLUE, PURPLE, BLACK;
  - ORIGIN_X=37, ORIGIN_Y=7, PITCH=30;
  - state enum for this FSM.
- **Sub-module `cell_lut`** (combinational): maps k and the cell code to base_x, base_y and colour. It is shared with any other block that needs cell geometry.

## Test plan
- **Empty board**: reset, `grid`=0, `start` pulse.
  - Exactly 9·CELL_SIZE² plot cycles, all with colour 3'b111.
  - First pixel (37,7); last pixel (97+CELL_SIZE-1, 67+CELL_SIZE-1).
  - `done` at t0+3610 for the default size.
- **Mixed board**: `grid`=18'b01_10_00_00_01_00_10_00_11.
  - Cell 0 draws 3'b011 at base (37,7); cell 1 draws 3'b101 at (67,7); cell 8 draws 3'b000 at (97,67).
  - Scoreboard checks every pixel.
- **Snapshot**: toggle `grid` to all-X during DRAW of cell 2. The whole frame still matches the snapshot taken at `start`.
- **Start while busy**: `start` pulses at t0+50 and in the `done` cycle. There is exactly one `done`, with no restart. A `start` one cycle after `done` is accepted.
- **Reset mid-frame**: assert `reset` during cell 4. All outputs go to 0 asynchronously and no `done` appears. A new `start` restarts at (37,7).
- **CELL_SIZE=1**: 9 plots at the nine cell origins, separated by LOAD gaps. `done` at t0+19.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, palette, board geometry, renderer states.
package ttt_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] O     = 2'd1;
  localparam logic [1:0] X     = 2'd2;
  localparam logic [1:0] RSVD  = 2'd3;

  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] LBLUE  = 3'b011;
  localparam logic [2:0] PURPLE = 3'b101;
  localparam logic [2:0] BLACK  = 3'b000;

  localparam logic [7:0] ORIGIN_X = 8'd37;
  localparam logic [6:0] ORIGIN_Y = 7'd7;
  localparam logic [7:0] PITCH    = 8'd30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  // Reserved code falls through to black; it is never treated as an error.
  function automatic logic [2:0] code_colour(input logic [1:0] code);
    case (code)
      EMPTY:   return WHITE;
      O:       return LBLUE;
      X:       return PURPLE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cell_lut.sv
// Cell geometry lookup: cell index and code to top-left pixel and fill colour.
module cell_lut
  import ttt_pkg::*;
(
  input  logic [3:0] k,
  input  logic [1:0] code,
  output logic [7:0] base_x,
  output logic [6:0] base_y,
  output logic [2:0] colour
);

  logic [1:0] row;
  logic [1:0] col;

  // Row/column split done as a table so no divider is inferred.
  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (k)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  // Origin plus pitch times position; all terms fit without truncation.
  always_comb begin
    base_x = ORIGIN_X + PITCH * 8'(col);
    base_y = ORIGIN_Y + 7'(PITCH) * 7'(row);
    colour = code_colour(code);
  end

endmodule

// File: rtl/board_renderer.sv
// Paints the nine board cells into the VGA frame buffer, one pixel per clock.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; grid snapshot taken when start is accepted
//   LOAD  | fetch cell k geometry/colour, present its first pixel next cycle
//   DRAW  | output register holds pixel (px,py) of cell k, plot high
//   DONE  | done pulse, busy still high, back to IDLE next cycle
//
// The output registers always hold the pixel described by (k, px, py), so the
// LOAD cycle already loads pixel (0,0) and the last pixel's cycle decides the
// next state directly.
module board_renderer
  import ttt_pkg::*;
#(
  parameter int CELL_SIZE = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] grid,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST = 5'(CELL_SIZE - 1);

  state_t      state, state_n;
  logic [17:0] grid_q, grid_q_n;
  logic [3:0]  k, k_n;
  logic [4:0]  px, px_n;
  logic [4:0]  py, py_n;
  logic [7:0]  base_x_q, base_x_n;
  logic [6:0]  base_y_q, base_y_n;
  logic [7:0]  x_n;
  logic [6:0]  y_n;
  logic [2:0]  colour_n;
  logic        plot_n, busy_n, done_n;

  logic [17:0] grid_sh;
  logic [1:0]  code;
  logic [7:0]  lut_x;
  logic [6:0]  lut_y;
  logic [2:0]  lut_c;

  // Cell k sits at grid_q[17-2k:16-2k]; shifting it to the top avoids a mux tree.
  assign grid_sh = grid_q << {k, 1'b0};
  assign code    = grid_sh[17:16];

  cell_lut u_cell_lut (
    .k      (k),
    .code   (code),
    .base_x (lut_x),
    .base_y (lut_y),
    .colour (lut_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and next-output logic; outputs default to holding, strobes to low.
  always_comb begin
    state_n  = state;
    grid_q_n = grid_q;
    k_n      = k;
    px_n     = px;
    py_n     = py;
    base_x_n = base_x_q;
    base_y_n = base_y_q;
    x_n      = x;
    y_n      = y;
    colour_n = colour;
    plot_n   = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          grid_q_n = grid;
          k_n      = 4'd0;
          busy_n   = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        base_x_n = lut_x;
        base_y_n = lut_y;
        px_n     = 5'd0;
        py_n     = 5'd0;
        x_n      = lut_x;
        y_n      = lut_y;
        colour_n = lut_c;
        plot_n   = 1'b1;
        state_n  = DRAW;
      end
      DRAW: begin
        if (px == LAST && py == LAST) begin
          if (k == 4'd8) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            k_n     = k + 4'd1;
            state_n = LOAD;
          end
        end else begin
          if (px == LAST) begin
            px_n = 5'd0;
            py_n = py + 5'd1;
          end else begin
            px_n = px + 5'd1;
          end
          x_n    = base_x_q + {3'b000, px_n};
          y_n    = base_y_q + {2'b00, py_n};
          plot_n = 1'b1;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_q   <= 18'd0;
      k        <= 4'd0;
      px       <= 5'd0;
      py       <= 5'd0;
      base_x_q <= 8'd0;
      base_y_q <= 7'd0;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      grid_q   <= grid_q_n;
      k        <= k_n;
      px       <= px_n;
      py       <= py_n;
      base_x_q <= base_x_n;
      base_y_q <= base_y_n;
      x        <= x_n;
      y        <= y_n;
      colour   <= colour_n;
      plot     <= plot_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: pixel scoreboard, frame timing, snapshot,
// ignored starts, async reset, and a CELL_SIZE=1 instance.
module tb_board_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [17:0] grid = 18'd0;

  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] c_a, c_b;
  logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  board_renderer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .grid(grid),
    .x(x_a), .y(y_a), .colour(c_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  board_renderer #(.CELL_SIZE(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .grid(grid),
    .x(x_b), .y(y_b), .colour(c_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  localparam logic [17:0] MIXED = 18'b01_10_00_00_01_00_10_00_11;
  localparam logic [17:0] ALL_X = 18'b10_10_10_10_10_10_10_10_10;
  localparam logic [17:0] ALL_O = 18'b01_01_01_01_01_01_01_01_01;

  int   n_assert = 0;
  int   n_fail = 0;
  pix_t sb[$];
  bit   sel = 1'b0;
  int   size = 20;

  logic [7:0] mx;
  logic [6:0] my;
  logic [2:0] mc;
  logic       mplot, mbusy, mdone;

  // Route the selected instance to the common checker signals.
  always_comb begin
    mx    = sel ? x_b    : x_a;
    my    = sel ? y_b    : y_a;
    mc    = sel ? c_b    : c_a;
    mplot = sel ? plot_b : plot_a;
    mbusy = sel ? busy_b : busy_a;
    mdone = sel ? done_b : done_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic push_frame(input logic [17:0] g, input int n);
    for (int k = 0; k < 9; k++) begin
      logic [1:0] code;
      logic [2:0] col;
      int bx, by;
      code = g[17-2*k -: 2];
      case (code)
        2'd0:    col = 3'b111;
        2'd1:    col = 3'b011;
        2'd2:    col = 3'b101;
        default: col = 3'b000;
      endcase
      bx = 37 + 30 * (k % 3);
      by = 7 + 30 * (k / 3);
      for (int py = 0; py < n; py++)
        for (int px = 0; px < n; px++)
          sb.push_back({8'(bx + px), 7'(by + py), col});
    end
  endtask

  // Called at a negedge; start is raised here and sampled at the next edge (t0).
  task automatic run_frame(input logic [17:0] g, input int toggle_c, input logic [17:0] g_alt,
                           input int extra_c, input bit start_at_done, input int exp_done);
    int   c, done_c, plots;
    pix_t e;
    sb.delete();
    push_frame(g, size);
    grid = g;
    drive_start(1'b1);
    c = 0;
    done_c = -1;
    plots = 0;
    while (done_c < 0 && c < exp_done + 50) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      drive_start(1'b0);
      if (c == toggle_c) grid = g_alt;
      if (c == extra_c) drive_start(1'b1);
      if (c == 1) begin
        check("load_gap_plot", {31'd0, mplot}, 32'd0);
        check("busy_after_start", {31'd0, mbusy}, 32'd1);
      end
      if (mplot) begin
        plots++;
        if (sb.size() == 0) check("pixel_overflow", plots, 9 * size * size);
        else begin
          e = sb.pop_front();
          check("pixel", {14'd0, mx, my, mc}, {14'd0, e});
        end
      end
      if (mdone) begin
        done_c = c;
        check("done_busy", {31'd0, mbusy}, 32'd1);
        if (start_at_done) drive_start(1'b1);
      end
    end
    check("done_cycle", done_c, exp_done);
    check("pixel_total", plots, 9 * size * size);
    check("sb_empty", sb.size(), 0);
    @(posedge clk);
    @(negedge clk);
    drive_start(1'b0);
    check("idle_busy", {31'd0, mbusy}, 32'd0);
    check("idle_done", {31'd0, mdone}, 32'd0);
    check("idle_plot", {31'd0, mplot}, 32'd0);
  endtask

  initial begin
    int dones;
    // Reset values, both instances.
    #1;
    check("rst_a", {x_a, y_a, c_a, plot_a, busy_a, done_a}, 32'd0);
    check("rst_b", {x_b, y_b, c_b, plot_b, busy_b, done_b}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {x_a, y_a, c_a, plot_a, busy_a, done_a}, 32'd0);

    // Empty board, mixed board, snapshot while cell 2 draws.
    run_frame(18'd0, -1, 18'd0, -1, 1'b0, 3610);
    run_frame(MIXED, -1, 18'd0, -1, 1'b0, 3610);
    run_frame(MIXED, 809, ALL_X, -1, 1'b0, 3610);

    // Starts mid-frame and in the done cycle are ignored; one cycle later is accepted.
    run_frame(ALL_X, -1, 18'd0, 50, 1'b1, 3610);
    run_frame(ALL_O, -1, 18'd0, -1, 1'b0, 3610);

    // Reset while cell 4 draws.
    sb.delete();
    grid = MIXED;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (1615) @(negedge clk);
    check("cell4_drawing", {31'd0, plot_a}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_outputs", {x_a, y_a, c_a, plot_a, busy_a, done_a}, 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || plot_a) dones++;
    end
    check("no_done_after_rst", dones, 0);
    run_frame(MIXED, -1, 18'd0, -1, 1'b0, 3610);

    // Single-pixel cells.
    sel = 1'b1;
    size = 1;
    @(negedge clk);
    run_frame(MIXED, -1, 18'd0, -1, 1'b0, 19);
    run_frame(18'd0, -1, 18'd0, -1, 1'b0, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
